alu_rs_scheduler: RTL and testbench
===================================

Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the common integer ALU.
- Buffers decoded ALU-class instructions from the dispatch stage and captures pending operands from the two CDB broadcast ports (ALU result and LSB result).
- Selects one operand-ready entry per cycle and drives the ALU input registers.
- Sits between the decoder/dispatch unit and the ALU. Results return to the ROB through the ALU, not through this block.

Parameters:
- RS_SIZE, 8, number of station entries (power of two).
- RS_BIT, 3, log2(RS_SIZE).
- ROB_BIT, 4, ROB tag width; must match the global ROB_BIT.

Ports:
- clk_in in 1: system clock.
- rst_in in 1: reset, asynchronous, active-low.
- rdy_in in 1: when low, all state freezes.
- clear in 1: pipeline flush on mispredict, synchronous.
- iss_valid in 1: dispatch request.
- iss_op in 3: funct3 (AddSub..And encoding).
- iss_op_addition in 1: sub/sra select.
- iss_has_imm in 1: second operand is the immediate.
- iss_imm in 32: sign-extended immediate.
- iss_vj, iss_vk in 32: operand values.
- iss_qj_busy, iss_qk_busy in 1: operand still pending.
- iss_qj, iss_qk in ROB_BIT: producer tags.
- iss_rob_entry in ROB_BIT: destination tag.
- full out 1: no free entry.
- cdb_alu_valid in 1, cdb_alu_rob in ROB_BIT, cdb_alu_val in 32: ALU broadcast.
- cdb_lsb_valid in 1, cdb_lsb_rob in ROB_BIT, cdb_lsb_val in 32: LSB broadcast.
- alu_valid out 1: issue strobe to the ALU.
- alu_vi, alu_vj, alu_imm out 32: operands.
- alu_op out 3, alu_op_addition out 1, alu_has_imm out 1: operation fields.
- alu_rob_entry out ROB_BIT: destination tag.

Behaviour:
- Reset: asynchronous on rst_in low. All entry busy bits cleared; every output register is 0, including alu_valid, operands, op fields and alu_rob_entry. full=0.
- Entry state:
  - busy, op fields, vj, vk, qj_busy, qk_busy, qj, qk, rob_entry.
  - If has_imm=1, qk_busy is forced 0 at accept.
  - An entry is ready when busy && !qj_busy && !qk_busy.
- full:
  - Combinational from registered state: 1 iff all RS_SIZE entries are busy.
  - An entry freed at a clock edge becomes visible as free only after that edge.
- Accept:
  - On a posedge with rdy_in=1, clear=0, iss_valid=1, full=0, write to the lowest-index non-busy entry.
  - iss_valid while full: the request is ignored. The dispatcher must hold it.
- Same-cycle forwarding at accept: if iss_qj_busy and a valid CDB port's tag equals iss_qj, store that port's value and clear qj_busy (same for qk). An entry accepted this way is ready next cycle.
- Wakeup, each cycle for every busy entry with a pending operand:
  - A matching valid CDB tag loads the value and clears the busy flag.
  - If both ports match the same tag, the ALU port wins. This is an illegal case with unique tags, but the result must be deterministic.
- Select:
  - Among entries ready in the current registered state, choose one (policy below).
  - On the edge: load the alu_* registers from it, set alu_valid=1, clear its busy bit.
  - If no entry is ready, alu_valid <= 0 and the other alu_* outputs hold.
- Latency:
  - Accept with ready operands at edge N → earliest alu_valid after edge N+1.
  - Wakeup at edge N → earliest issue at edge N+1.
- Throughput: one issue per cycle. Accept and issue in the same cycle are allowed, including to the same index only once it has been freed.
- clear=1 (with rdy_in=1):
  - All busy bits clear and alu_valid <= 0.
  - A concurrent accept is discarded.
  - clear overrides accept, wakeup and select.
- rdy_in=0: no state or output change, regardless of clear, iss_valid or CDB inputs.
- Async reset mid-operation: takes effect immediately, and entries are lost.

Optional Feature:
- Macro: ALU_RS_AGE_SEL_EN.
- Defined: each entry holds a RS_BIT-wide age rank.
  - At accept, the new entry gets rank = number of busy entries.
  - When an entry issues, every entry with a larger rank decrements.
  - Select picks the ready entry with the smallest rank (oldest first).
- Undefined: select picks the lowest-index ready entry, and no age storage is built.

Test Plan:
- Accept op=Xor, vj=0x0F0F0F0F, vk=0x00FF00FF, no pending operands → alu_valid pulses one cycle later with alu_vi=0x0F0F0F0F, alu_vj=0x00FF00FF, alu_op=3'b100, alu_rob_entry equal to iss_rob_entry; full stays 0.
- Pending-operand wakeup:
  - Accept add with qj_busy=1, qj=5; alu_valid stays 0.
  - Pulse cdb_lsb_valid with rob=5, val=0x10 → issue on the next edge with alu_vi=0x10.
- Same-cycle forwarding: iss_qj=3 while cdb_alu_valid, rob=3, val=0x7 in the same cycle → entry accepted ready; issues next cycle with alu_vi=7.
- Fill and drain:
  - Fill all 8 entries with qj pending, tags 0..7; after the 8th accept, full=1.
  - A 9th iss_valid is ignored.
  - Broadcast tag 2 → only that entry issues; full drops after the issue edge.
- Flush priority: with 4 busy entries, assert clear together with iss_valid → next cycle alu_valid=0, full=0, and no entry issues afterwards even when CDB tags match.
- Select-order check:
  - Accept A then B into free indices 1 and 0 respectively, then wake both in the same cycle.
  - With ALU_RS_AGE_SEL_EN: A issues first.
  - Without it: index 0 (B) issues first.
  - In both cases the other entry issues in the following cycle.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rs_scheduler : ALU reservation station with CDB capture and issue      |
// | Optional: ALU_RS_AGE_SEL_EN selects oldest-ready instead of lowest index    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_rs_scheduler #(
   parameter int RS_SIZE = 8,
   parameter int RS_BIT  = 3,
   parameter int ROB_BIT = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               clear,
   input  logic               iss_valid,
   input  logic [2:0]         iss_op,
   input  logic               iss_op_addition,
   input  logic               iss_has_imm,
   input  logic [31:0]        iss_imm,
   input  logic [31:0]        iss_vj,
   input  logic [31:0]        iss_vk,
   input  logic               iss_qj_busy,
   input  logic               iss_qk_busy,
   input  logic [ROB_BIT-1:0] iss_qj,
   input  logic [ROB_BIT-1:0] iss_qk,
   input  logic [ROB_BIT-1:0] iss_rob_entry,
   output logic               full,
   input  logic               cdb_alu_valid,
   input  logic [ROB_BIT-1:0] cdb_alu_rob,
   input  logic [31:0]        cdb_alu_val,
   input  logic               cdb_lsb_valid,
   input  logic [ROB_BIT-1:0] cdb_lsb_rob,
   input  logic [31:0]        cdb_lsb_val,
   output logic               alu_valid,
   output logic [31:0]        alu_vi,
   output logic [31:0]        alu_vj,
   output logic [31:0]        alu_imm,
   output logic [2:0]         alu_op,
   output logic               alu_op_addition,
   output logic               alu_has_imm,
   output logic [ROB_BIT-1:0] alu_rob_entry
);

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [2:0]         op_q      [RS_SIZE];
   logic [2:0]         op_d      [RS_SIZE];
   logic               op_add_q  [RS_SIZE];
   logic               op_add_d  [RS_SIZE];
   logic               has_imm_q [RS_SIZE];
   logic               has_imm_d [RS_SIZE];
   logic [31:0]        imm_q     [RS_SIZE];
   logic [31:0]        imm_d     [RS_SIZE];
   logic [31:0]        vj_q      [RS_SIZE];
   logic [31:0]        vj_d      [RS_SIZE];
   logic [31:0]        vk_q      [RS_SIZE];
   logic [31:0]        vk_d      [RS_SIZE];
   logic               qj_busy_q [RS_SIZE];
   logic               qj_busy_d [RS_SIZE];
   logic               qk_busy_q [RS_SIZE];
   logic               qk_busy_d [RS_SIZE];
   logic [ROB_BIT-1:0] qj_q      [RS_SIZE];
   logic [ROB_BIT-1:0] qj_d      [RS_SIZE];
   logic [ROB_BIT-1:0] qk_q      [RS_SIZE];
   logic [ROB_BIT-1:0] qk_d      [RS_SIZE];
   logic [ROB_BIT-1:0] rob_q     [RS_SIZE];
   logic [ROB_BIT-1:0] rob_d     [RS_SIZE];
`ifdef ALU_RS_AGE_SEL_EN
   logic [RS_BIT-1:0]  rank_q    [RS_SIZE];
   logic [RS_BIT-1:0]  rank_d    [RS_SIZE];
   logic [RS_BIT-1:0]  best_rank;
   logic [RS_BIT:0]    new_rank;
`endif

   logic               alu_valid_q, alu_valid_d;
   logic [31:0]        alu_vi_q, alu_vi_d;
   logic [31:0]        alu_vj_q, alu_vj_d;
   logic [31:0]        alu_imm_q, alu_imm_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic               alu_op_add_q, alu_op_add_d;
   logic               alu_has_imm_q, alu_has_imm_d;
   logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

   logic [RS_SIZE-1:0] ready;
   logic [RS_BIT-1:0]  sel_idx, free_idx;
   logic               sel_found, free_found;
   logic [RS_BIT:0]    busy_cnt;

   // Returns {still_pending, value}; the ALU port wins when both ports match.
   function automatic logic [32:0] capture(input logic pend, input logic [ROB_BIT-1:0] tag,
                                           input logic [31:0] val);
      if (pend && cdb_alu_valid && cdb_alu_rob == tag) return {1'b0, cdb_alu_val};
      if (pend && cdb_lsb_valid && cdb_lsb_rob == tag) return {1'b0, cdb_lsb_val};
      return {pend, val};
   endfunction

   assign full = &busy_q;

   always_comb begin
      ready      = '0;
      sel_idx    = '0;
      sel_found  = 1'b0;
      free_idx   = '0;
      free_found = 1'b0;
      busy_cnt   = '0;
`ifdef ALU_RS_AGE_SEL_EN
      best_rank  = '0;
`endif
      for (int i = 0; i < RS_SIZE; i++) begin
         ready[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
         busy_cnt = busy_cnt + {{RS_BIT{1'b0}}, busy_q[i]};
         if (!busy_q[i] && !free_found) begin
            free_idx   = RS_BIT'(i);
            free_found = 1'b1;
         end
`ifdef ALU_RS_AGE_SEL_EN
         if (ready[i] && (!sel_found || rank_q[i] < best_rank)) begin
            sel_idx   = RS_BIT'(i);
            best_rank = rank_q[i];
            sel_found = 1'b1;
         end
`else
         if (ready[i] && !sel_found) begin
            sel_idx   = RS_BIT'(i);
            sel_found = 1'b1;
         end
`endif
      end
   end

   always_comb begin
      busy_d        = busy_q;
      alu_valid_d   = alu_valid_q;
      alu_vi_d      = alu_vi_q;
      alu_vj_d      = alu_vj_q;
      alu_imm_d     = alu_imm_q;
      alu_op_d      = alu_op_q;
      alu_op_add_d  = alu_op_add_q;
      alu_has_imm_d = alu_has_imm_q;
      alu_rob_d     = alu_rob_q;
`ifdef ALU_RS_AGE_SEL_EN
      new_rank      = busy_cnt - {{RS_BIT{1'b0}}, sel_found};
`endif
      for (int i = 0; i < RS_SIZE; i++) begin
         op_d[i]      = op_q[i];
         op_add_d[i]  = op_add_q[i];
         has_imm_d[i] = has_imm_q[i];
         imm_d[i]     = imm_q[i];
         vj_d[i]      = vj_q[i];
         vk_d[i]      = vk_q[i];
         qj_busy_d[i] = qj_busy_q[i];
         qk_busy_d[i] = qk_busy_q[i];
         qj_d[i]      = qj_q[i];
         qk_d[i]      = qk_q[i];
         rob_d[i]     = rob_q[i];
`ifdef ALU_RS_AGE_SEL_EN
         rank_d[i]    = rank_q[i];
`endif
      end

      if (rdy_in) begin
         if (clear) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i]) begin
                  {qj_busy_d[i], vj_d[i]} = capture(qj_busy_q[i], qj_q[i], vj_q[i]);
                  {qk_busy_d[i], vk_d[i]} = capture(qk_busy_q[i], qk_q[i], vk_q[i]);
               end
            end

            alu_valid_d = sel_found;
            if (sel_found) begin
               alu_vi_d        = vj_q[sel_idx];
               alu_vj_d        = vk_q[sel_idx];
               alu_imm_d       = imm_q[sel_idx];
               alu_op_d        = op_q[sel_idx];
               alu_op_add_d    = op_add_q[sel_idx];
               alu_has_imm_d   = has_imm_q[sel_idx];
               alu_rob_d       = rob_q[sel_idx];
               busy_d[sel_idx] = 1'b0;
`ifdef ALU_RS_AGE_SEL_EN
               for (int i = 0; i < RS_SIZE; i++) begin
                  if (busy_q[i] && rank_q[i] > rank_q[sel_idx]) rank_d[i] = rank_q[i] - 1'b1;
               end
`endif
            end

            // The free slot is non-busy in registered state, so it never collides with sel_idx.
            if (iss_valid && !full) begin
               busy_d[free_idx]    = 1'b1;
               op_d[free_idx]      = iss_op;
               op_add_d[free_idx]  = iss_op_addition;
               has_imm_d[free_idx] = iss_has_imm;
               imm_d[free_idx]     = iss_imm;
               qj_d[free_idx]      = iss_qj;
               qk_d[free_idx]      = iss_qk;
               rob_d[free_idx]     = iss_rob_entry;
               {qj_busy_d[free_idx], vj_d[free_idx]} = capture(iss_qj_busy, iss_qj, iss_vj);
               {qk_busy_d[free_idx], vk_d[free_idx]} =
                  capture(iss_qk_busy && !iss_has_imm, iss_qk, iss_vk);
`ifdef ALU_RS_AGE_SEL_EN
               rank_d[free_idx]    = new_rank[RS_BIT-1:0];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q        <= '0;
         alu_valid_q   <= 1'b0;
         alu_vi_q      <= '0;
         alu_vj_q      <= '0;
         alu_imm_q     <= '0;
         alu_op_q      <= '0;
         alu_op_add_q  <= 1'b0;
         alu_has_imm_q <= 1'b0;
         alu_rob_q     <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]      <= '0;
            op_add_q[i]  <= 1'b0;
            has_imm_q[i] <= 1'b0;
            imm_q[i]     <= '0;
            vj_q[i]      <= '0;
            vk_q[i]      <= '0;
            qj_busy_q[i] <= 1'b0;
            qk_busy_q[i] <= 1'b0;
            qj_q[i]      <= '0;
            qk_q[i]      <= '0;
            rob_q[i]     <= '0;
`ifdef ALU_RS_AGE_SEL_EN
            rank_q[i]    <= '0;
`endif
         end
      end else begin
         busy_q        <= busy_d;
         alu_valid_q   <= alu_valid_d;
         alu_vi_q      <= alu_vi_d;
         alu_vj_q      <= alu_vj_d;
         alu_imm_q     <= alu_imm_d;
         alu_op_q      <= alu_op_d;
         alu_op_add_q  <= alu_op_add_d;
         alu_has_imm_q <= alu_has_imm_d;
         alu_rob_q     <= alu_rob_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]      <= op_d[i];
            op_add_q[i]  <= op_add_d[i];
            has_imm_q[i] <= has_imm_d[i];
            imm_q[i]     <= imm_d[i];
            vj_q[i]      <= vj_d[i];
            vk_q[i]      <= vk_d[i];
            qj_busy_q[i] <= qj_busy_d[i];
            qk_busy_q[i] <= qk_busy_d[i];
            qj_q[i]      <= qj_d[i];
            qk_q[i]      <= qk_d[i];
            rob_q[i]     <= rob_d[i];
`ifdef ALU_RS_AGE_SEL_EN
            rank_q[i]    <= rank_d[i];
`endif
         end
      end
   end

   assign alu_valid       = alu_valid_q;
   assign alu_vi          = alu_vi_q;
   assign alu_vj          = alu_vj_q;
   assign alu_imm         = alu_imm_q;
   assign alu_op          = alu_op_q;
   assign alu_op_addition = alu_op_add_q;
   assign alu_has_imm     = alu_has_imm_q;
   assign alu_rob_entry   = alu_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_rs_scheduler : scoreboard bench for alu_rs_scheduler                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_rs_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        clear = 1'b0;
   logic        iss_valid = 1'b0;
   logic [2:0]  iss_op = '0;
   logic        iss_op_addition = 1'b0;
   logic        iss_has_imm = 1'b0;
   logic [31:0] iss_imm = '0;
   logic [31:0] iss_vj = '0;
   logic [31:0] iss_vk = '0;
   logic        iss_qj_busy = 1'b0;
   logic        iss_qk_busy = 1'b0;
   logic [3:0]  iss_qj = '0;
   logic [3:0]  iss_qk = '0;
   logic [3:0]  iss_rob_entry = '0;
   logic        full;
   logic        cdb_alu_valid = 1'b0;
   logic [3:0]  cdb_alu_rob = '0;
   logic [31:0] cdb_alu_val = '0;
   logic        cdb_lsb_valid = 1'b0;
   logic [3:0]  cdb_lsb_rob = '0;
   logic [31:0] cdb_lsb_val = '0;
   logic        alu_valid;
   logic [31:0] alu_vi, alu_vj, alu_imm;
   logic [2:0]  alu_op;
   logic        alu_op_addition, alu_has_imm;
   logic [3:0]  alu_rob_entry;

   typedef struct packed {
      logic [31:0] vi;
      logic [31:0] vj;
      logic [31:0] imm;
      logic [2:0]  op;
      logic        add;
      logic        has_imm;
      logic [3:0]  rob;
   } issue_t;

   issue_t exp_q[$];
   issue_t mon_act, mon_exp;
   int     checks = 0;
   int     errors = 0;

   always #5 clk_in = ~clk_in;

   alu_rs_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_op_addition(iss_op_addition),
      .iss_has_imm(iss_has_imm), .iss_imm(iss_imm), .iss_vj(iss_vj), .iss_vk(iss_vk),
      .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy), .iss_qj(iss_qj), .iss_qk(iss_qk),
      .iss_rob_entry(iss_rob_entry), .full(full),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
      .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
      .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm),
      .alu_op(alu_op), .alu_op_addition(alu_op_addition), .alu_has_imm(alu_has_imm),
      .alu_rob_entry(alu_rob_entry)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic acc(input logic [2:0] op, input logic add, input logic hi, input logic [31:0] imm,
                      input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                      input logic [3:0] rob);
      iss_valid = 1'b1; iss_op = op; iss_op_addition = add; iss_has_imm = hi; iss_imm = imm;
      iss_vj = vj; iss_vk = vk; iss_qj_busy = qjb; iss_qj = qj; iss_qk_busy = qkb; iss_qk = qk;
      iss_rob_entry = rob;
   endtask

   task automatic push(input logic [31:0] vi, input logic [31:0] vj, input logic [31:0] imm,
                       input logic [2:0] op, input logic add, input logic hi, input logic [3:0] rob);
      exp_q.push_back('{vi: vi, vj: vj, imm: imm, op: op, add: add, has_imm: hi, rob: rob});
   endtask

   // Monitor: every issue strobe must match the oldest outstanding expectation.
   always @(negedge clk_in) begin
      if (rst_in && alu_valid) begin
         mon_act = {alu_vi, alu_vj, alu_imm, alu_op, alu_op_addition, alu_has_imm, alu_rob_entry};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: actual rob=%0d vi=%h required no issue",
                     alu_rob_entry, alu_vi);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL issue: actual=%h required=%h", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      step();
      check("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
      check("rst_full", {31'b0, full}, 32'd0);
      check("rst_alu_vi", alu_vi, 32'd0);
      check("rst_alu_rob", {28'b0, alu_rob_entry}, 32'd0);
      rst_in = 1'b1;
      step();

      // Ready XOR: issues exactly one edge after acceptance
      acc(3'b100, 1'b0, 1'b0, 32'd0, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
      push(32'h0F0F0F0F, 32'h00FF00FF, 32'd0, 3'b100, 1'b0, 1'b0, 4'd1);
      step();
      iss_valid = 1'b0;
      check("xor_latency_early", {31'b0, alu_valid}, 32'd0);
      check("xor_full", {31'b0, full}, 32'd0);
      step();
      check("xor_latency_issue", {31'b0, alu_valid}, 32'd1);
      step();

      // Immediate operand ignores a pending qk
      acc(3'b000, 1'b0, 1'b1, 32'hFFFFFFF0, 32'd5, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd3);
      push(32'd5, 32'd0, 32'hFFFFFFF0, 3'b000, 1'b0, 1'b1, 4'd3);
      step();
      iss_valid = 1'b0;
      step();
      step();

      // Pending qj woken by LSB broadcast
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd3, 1'b1, 4'd5, 1'b0, 4'd0, 4'd2);
      step();
      iss_valid = 1'b0;
      step();
      step();
      check("pending_no_issue", {31'b0, alu_valid}, 32'd0);
      cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd5; cdb_lsb_val = 32'h10;
      push(32'h10, 32'd3, 32'd0, 3'b000, 1'b0, 1'b0, 4'd2);
      step();
      cdb_lsb_valid = 1'b0;
      check("wake_latency_early", {31'b0, alu_valid}, 32'd0);
      step();
      check("wake_issue", {31'b0, alu_valid}, 32'd1);
      step();

      // Same-cycle forwarding at accept
      acc(3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 32'd9, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
      cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd3; cdb_alu_val = 32'h7;
      push(32'h7, 32'd9, 32'd0, 3'b000, 1'b1, 1'b0, 4'd4);
      step();
      iss_valid = 1'b0; cdb_alu_valid = 1'b0;
      step();
      check("fwd_issue", {31'b0, alu_valid}, 32'd1);
      step();

      // Fill all eight entries, then wake only tag 2
      for (int i = 0; i < 8; i++) begin
         acc(3'b111, 1'b0, 1'b0, 32'd0, 32'd0, i, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
         step();
         if (i == 6) check("fill_full_7", {31'b0, full}, 32'd0);
      end
      check("fill_full_8", {31'b0, full}, 32'd1);
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'h99, 32'h99, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      step();
      iss_valid = 1'b0;
      check("ninth_full", {31'b0, full}, 32'd1);
      cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd2; cdb_alu_val = 32'h22;
      push(32'h22, 32'd2, 32'd0, 3'b111, 1'b0, 1'b0, 4'd2);
      step();
      cdb_alu_valid = 1'b0;
      check("drain_full_wake", {31'b0, full}, 32'd1);
      step();
      check("drain_full_issue", {31'b0, full}, 32'd0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_full", {31'b0, full}, 32'd0);

      // Flush overrides a concurrent accept
      for (int i = 0; i < 4; i++) begin
         acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(8 + i));
         step();
      end
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
      clear = 1'b1;
      step();
      clear = 1'b0; iss_valid = 1'b0;
      check("flush_alu_valid", {31'b0, alu_valid}, 32'd0);
      check("flush_full", {31'b0, full}, 32'd0);
      for (int t = 8; t < 12; t++) begin
         cdb_alu_valid = 1'b1; cdb_alu_rob = 4'(t); cdb_alu_val = 32'hDEAD;
         step();
      end
      cdb_alu_valid = 1'b0;
      step();
      step();

      // Both CDB ports match the same tag: the ALU value is taken
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd6);
      step();
      iss_valid = 1'b0;
      cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd6; cdb_alu_val = 32'hA;
      cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd6; cdb_lsb_val = 32'hB;
      push(32'hA, 32'd1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd6);
      step();
      cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
      step();
      step();

      // rdy_in low freezes everything, including accept
      rdy_in = 1'b0;
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
      step();
      step();
      check("rdy_hold_valid", {31'b0, alu_valid}, 32'd0);
      iss_valid = 1'b0; rdy_in = 1'b1;
      step();
      step();

      // Select order: A lands in index 1, B in index 0, both woken together
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 1'b1, 4'd13, 1'b0, 4'd0, 4'd13);
      step();
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'hA1, 1'b1, 4'd14, 1'b0, 4'd0, 4'd10);
      step();
      iss_valid = 1'b0;
      cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd13; cdb_alu_val = 32'h13;
      push(32'h13, 32'd1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd13);
      step();
      cdb_alu_valid = 1'b0;
      step();
      acc(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'hB1, 1'b1, 4'd15, 1'b0, 4'd0, 4'd11);
      step();
      iss_valid = 1'b0;
      cdb_alu_valid = 1'b1; cdb_alu_rob = 4'd14; cdb_alu_val = 32'hAA;
      cdb_lsb_valid = 1'b1; cdb_lsb_rob = 4'd15; cdb_lsb_val = 32'hBB;
`ifdef ALU_RS_AGE_SEL_EN
      push(32'hAA, 32'hA1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd10);
      push(32'hBB, 32'hB1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd11);
`else
      push(32'hBB, 32'hB1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd11);
      push(32'hAA, 32'hA1, 32'd0, 3'b000, 1'b0, 1'b0, 4'd10);
`endif
      step();
      cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
      step();
      check("order_first", {31'b0, alu_valid}, 32'd1);
      step();
      check("order_second", {31'b0, alu_valid}, 32'd1);

      for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
      step();
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
